// File: rtl/if_sdp_ram_pkg.sv
// Shared types and helpers for the single-clock SDP RAM with hardware clear.
// Optional feature: IF_SDP_RAM_BYP_EN selects write-first collision handling.
package if_sdp_ram_pkg;

    // Clear FSM: sweep zeros through the array, then run normally.
    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    // Number of byte lanes in one data word.
    function automatic int NB(input int dw, input int bw);
        return dw / bw;
    endfunction

    // True when the data word splits into whole lanes.
    function automatic bit lanes_fit(input int dw, input int bw);
        return (bw > 0) && ((dw % bw) == 0);
    endfunction

endpackage

// File: rtl/if_sdp_ram_core.sv
// Bare block-RAM array: per-lane write port and a registered read port.
// Kept free of bypass/mux logic so it maps onto a block RAM primitive.
module if_sdp_ram_core
    import if_sdp_ram_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int BW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [NB(DW, BW)-1:0]  be,
    input  logic [AW-1:0]          wa,
    input  logic [DW-1:0]          wd,
    input  logic                   re,
    input  logic [AW-1:0]          ra,
    output logic [DW-1:0]          rd_p0
);

    localparam int LANES = NB(DW, BW);
    localparam int DEPTH = 2 ** AW;

    (* syn_ramstyle = "block_ram" *) logic [DW-1:0] mem [DEPTH];

    // Per-lane write: only enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we && be[i]) begin
                mem[wa][i*BW +: BW] <= wd[i*BW +: BW];
            end
        end
    end

    // First read register; read-first against a same-edge write, holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_p0 <= '0;
        end else if (re) begin
            rd_p0 <= mem[ra];
        end
    end

endmodule

// File: rtl/if_sdp_ram_clr.sv
// Single-clock SDP RAM with byte enables, 1/2-cycle read pipeline and a
// zero-sweep of the whole array after every reset.
// Optional feature: IF_SDP_RAM_BYP_EN -> same-address collisions are write-first
// (forwarding register + per-lane mux); undefined -> read-first, pure BRAM.
module if_sdp_ram_clr
    import if_sdp_ram_pkg::*;
#(
    parameter int    AW  = 4,
    parameter int    DW  = 8,
    parameter int    BW  = 8,
    parameter string OR  = "TRUE",
    parameter string CLR = "TRUE"
) (
    input  logic                   Ck,
    input  logic                   Rst,
    output logic                   Busy,
    input  logic                   A_CE,
    input  logic                   A_WE,
    input  logic [NB(DW, BW)-1:0]  A_BE,
    input  logic [AW-1:0]          A_Ad,
    input  logic [DW-1:0]          A_WD,
    input  logic                   B_CE,
    input  logic [AW-1:0]          B_Ad,
    output logic [DW-1:0]          B_RD,
    output logic                   B_RV
);

    localparam int             LANES   = NB(DW, BW);
    localparam bit             CLR_EN  = (CLR == "TRUE");
    localparam bit             OUT_REG = (OR == "TRUE");
    localparam logic [AW-1:0]  CP_LAST = '1;

    if (!lanes_fit(DW, BW)) begin : g_lane_chk
        $error("if_sdp_ram_clr: DW must be a whole multiple of BW");
    end

    state_t            state, state_nx;
    logic [AW-1:0]     cp, cp_nx;
    logic              wr_acc, rd_acc;
    logic              mem_we;
    logic [LANES-1:0]  mem_be;
    logic [AW-1:0]     mem_wa;
    logic [DW-1:0]     mem_wd;
    logic [DW-1:0]     core_rd_p0;
    logic [DW-1:0]     data_p0;
    logic              vld_p0;

    // Clear FSM state and sweep pointer.
    always_ff @(posedge Ck) begin
        if (Rst) begin
            state <= CLR_EN ? ST_CLR : ST_RUN;
            cp    <= '0;
        end else begin
            state <= state_nx;
            cp    <= cp_nx;
        end
    end

    // Sweep advances one address per cycle and stops on the last one (no wrap).
    always_comb begin
        state_nx = state;
        cp_nx    = cp;
        case (state)
            ST_CLR: begin
                if (cp == CP_LAST) begin
                    state_nx = ST_RUN;
                end else begin
                    cp_nx = cp + 1'b1;
                end
            end
            ST_RUN:  state_nx = ST_RUN;
            default: state_nx = ST_RUN;
        endcase
    end

    assign Busy = (state == ST_CLR);

    // Port muxing: the sweep owns the write port while busy, user ports are dropped.
    assign wr_acc = !Rst && !Busy && A_CE && A_WE;
    assign rd_acc = !Rst && !Busy && B_CE;
    assign mem_we = (!Rst && Busy) || wr_acc;
    assign mem_be = Busy ? '1 : A_BE;
    assign mem_wa = Busy ? cp : A_Ad;
    assign mem_wd = Busy ? '0 : A_WD;

    if_sdp_ram_core #(
        .AW (AW),
        .DW (DW),
        .BW (BW)
    ) u_core (
        .clk   (Ck),
        .rst   (Rst),
        .we    (mem_we),
        .be    (mem_be),
        .wa    (mem_wa),
        .wd    (mem_wd),
        .re    (rd_acc),
        .ra    (B_Ad),
        .rd_p0 (core_rd_p0)
    );

    // ---- stage p0: array read register, valid travels alongside ----
    always_ff @(posedge Ck) begin
        if (Rst) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
        end
    end

`ifdef IF_SDP_RAM_BYP_EN
    logic              hit_p0;
    logic [LANES-1:0]  byp_be_p0;
    logic [DW-1:0]     byp_wd_p0;

    // Capture the colliding write alongside each read so its lanes can override.
    always_ff @(posedge Ck) begin
        if (Rst) begin
            hit_p0    <= 1'b0;
            byp_be_p0 <= '0;
            byp_wd_p0 <= '0;
        end else if (rd_acc) begin
            hit_p0    <= wr_acc && (A_Ad == B_Ad);
            byp_be_p0 <= A_BE;
            byp_wd_p0 <= A_WD;
        end
    end

    // Per-lane forwarding mux turns the read-first array result into write-first.
    always_comb begin
        data_p0 = core_rd_p0;
        for (int i = 0; i < LANES; i++) begin
            if (hit_p0 && byp_be_p0[i]) begin
                data_p0[i*BW +: BW] = byp_wd_p0[i*BW +: BW];
            end
        end
    end
`else
    assign data_p0 = core_rd_p0;
`endif

    if (OUT_REG) begin : g_oreg
        logic [DW-1:0] rd_p1;
        logic          vld_p1;

        // ---- stage p1: output register, loads only on valid so data holds ----
        always_ff @(posedge Ck) begin
            if (Rst) begin
                rd_p1  <= '0;
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    rd_p1 <= data_p0;
                end
            end
        end

        assign B_RD = rd_p1;
        assign B_RV = vld_p1;
    end else begin : g_noreg
        assign B_RD = data_p0;
        assign B_RV = vld_p0;
    end

endmodule

// File: tb/tb_if_sdp_ram_clr.sv
// Randomized + directed bench for if_sdp_ram_clr (AW=4, DW=32, BW=8, OR="TRUE").
// Reference model: a plain word array, a countdown for the clear sweep and a
// queue of expected read results tagged with the cycle they must appear.
module tb_if_sdp_ram_clr;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int NBL   = DW / BW;
    localparam int DEPTH = 2 ** AW;
    localparam int LAT   = 2;

    logic           Ck = 1'b0;
    logic           Rst = 1'b1;
    logic           Busy;
    logic           A_CE = 1'b0;
    logic           A_WE = 1'b0;
    logic [NBL-1:0] A_BE = '0;
    logic [AW-1:0]  A_Ad = '0;
    logic [DW-1:0]  A_WD = '0;
    logic           B_CE = 1'b0;
    logic [AW-1:0]  B_Ad = '0;
    logic [DW-1:0]  B_RD;
    logic           B_RV;

    always #5 Ck = ~Ck;

    if_sdp_ram_clr #(
        .AW  (AW),
        .DW  (DW),
        .BW  (BW),
        .OR  ("TRUE"),
        .CLR ("TRUE")
    ) dut (
        .Ck   (Ck),
        .Rst  (Rst),
        .Busy (Busy),
        .A_CE (A_CE),
        .A_WE (A_WE),
        .A_BE (A_BE),
        .A_Ad (A_Ad),
        .A_WD (A_WD),
        .B_CE (B_CE),
        .B_Ad (B_Ad),
        .B_RD (B_RD),
        .B_RV (B_RV)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] mem_m [DEPTH];
    rd_t           pend[$];
    int            clr_left = 0;
    int            cyc = 0;
    logic [DW-1:0] last_rd = '0;
    bit            model_ok = 1'b0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [NBL-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NBL; i++) if (be[i]) r[i*BW +: BW] = wd[i*BW +: BW];
        return r;
    endfunction

    // Called right after each rising edge with the inputs that edge sampled.
    // Those inputs were presented after the previous edge, so the request is
    // "at edge cyc-1" and its result is due after edge cyc-1+LAT.
    task automatic model_edge();
        logic [DW-1:0] rv;
        logic [DW-1:0] nw;
        if (Rst) begin
            clr_left = DEPTH;
            pend.delete();
            last_rd  = '0;
            model_ok = 1'b1;
        end else if (clr_left > 0) begin
            mem_m[DEPTH - clr_left] = '0;
            clr_left--;
        end else begin
            nw = merge(mem_m[A_Ad], A_WD, A_BE);
            if (B_CE) begin
                rv = mem_m[B_Ad];
`ifdef IF_SDP_RAM_BYP_EN
                if (A_CE && A_WE && (A_Ad == B_Ad)) rv = nw;
`endif
                pend.push_back('{due: cyc - 1 + LAT, data: rv});
            end
            if (A_CE && A_WE) mem_m[A_Ad] = nw;
        end
    endtask

    task automatic check_outputs();
        if (!model_ok) return;
        check_val("busy", 32'(Busy), 32'(clr_left > 0));
        if (pend.size() > 0 && pend[0].due == cyc) begin
            check_val("b_rv", 32'(B_RV), 32'd1);
            check_val("b_rd", B_RD, pend[0].data);
            last_rd = pend[0].data;
            void'(pend.pop_front());
        end else begin
            check_val("b_rv_idle", 32'(B_RV), 32'd0);
            check_val("b_rd_hold", B_RD, last_rd);
        end
    endtask

    task automatic tick();
        @(posedge Ck);
        cyc++;
        model_edge();
        @(negedge Ck);
        check_outputs();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        A_CE = 1'b0;
        A_WE = 1'b0;
        B_CE = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NBL-1:0] be);
        A_CE = 1'b1;
        A_WE = 1'b1;
        A_Ad = a;
        A_WD = d;
        A_BE = be;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        B_CE = 1'b1;
        B_Ad = a;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d);
        idle();
        rd(a);
        tick();
        idle();
        tick();
        d = B_RD;
    endtask

    // Counts cycles with Busy high, bounded so a stuck Busy cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            n;
        logic [DW-1:0] d;

        // Reset state
        tick();
        tick();
        check_val("rst_busy", 32'(Busy), 32'd1);
        check_val("rst_rv", 32'(B_RV), 32'd0);
        check_val("rst_rd", B_RD, 32'd0);

        // Clear sweep length, with a write and a read attempted while busy
        Rst = 1'b0;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            if (n == 2) begin
                wr(2, 32'h0000_00FF, 4'hF);
                rd(2);
            end else begin
                idle();
            end
            n++;
            tick();
        end
        idle();
        check_val("busy_len", n, 32'd16);

        // Whole array reads back zero after the sweep (back-to-back reads)
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i));
            tick();
        end
        idle();
        tick();
        tick();
        read_word(2, d);
        check_val("busy_mask_a2", d, 32'd0);

        // Byte enables
        wr(5, 32'hAABB_CCDD, 4'b1111);
        tick();
        wr(5, 32'h1122_3344, 4'b0101);
        tick();
        read_word(5, d);
        check_val("be_merge", d, 32'hAA22_CC44);

        // A_BE=0 is a no-op
        wr(5, 32'hFFFF_FFFF, 4'b0000);
        tick();
        read_word(5, d);
        check_val("be_none", d, 32'hAA22_CC44);

        // Latency: three consecutive requests, results one per cycle
        wr(7, 32'h0707_0707, 4'hF);
        tick();
        wr(8, 32'h0808_0808, 4'hF);
        tick();
        wr(9, 32'h0909_0909, 4'hF);
        tick();
        idle();
        rd(7);
        tick();
        check_val("lat_rv_early", 32'(B_RV), 32'd0);
        rd(8);
        tick();
        check_val("lat_d7", B_RD, 32'h0707_0707);
        rd(9);
        tick();
        check_val("lat_d8", B_RD, 32'h0808_0808);
        idle();
        tick();
        check_val("lat_d9", B_RD, 32'h0909_0909);
        tick();

        // Same-address collision
        wr(3, 32'h0000_0010, 4'hF);
        tick();
        wr(3, 32'h0000_0055, 4'hF);
        rd(3);
        tick();
        idle();
        tick();
`ifdef IF_SDP_RAM_BYP_EN
        check_val("collide", B_RD, 32'h0000_0055);
`else
        check_val("collide", B_RD, 32'h0000_0010);
`endif
        tick();

        // Reset mid-sweep: restart from 0, full length again
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        count_busy(n);
        check_val("busy_len_restart", n, 32'd16);
        read_word(7, d);
        check_val("swept_a7", d, 32'd0);
        read_word(5, d);
        check_val("swept_a5", d, 32'd0);

        // Reset mid-read: the in-flight result must never appear
        wr(4, 32'h0000_1234, 4'hF);
        tick();
        idle();
        rd(4);
        tick();
        idle();
        Rst = 1'b1;
        tick();
        check_val("rst_midread_rv", 32'(B_RV), 32'd0);
        Rst = 1'b0;
        count_busy(n);
        check_val("busy_len_midread", n, 32'd16);

        // Randomized traffic, narrow address range half the time to force collisions
        for (int k = 0; k < 3000; k++) begin
            Rst  = ($urandom_range(0, 399) == 0);
            A_CE = $urandom_range(0, 3) != 0;
            A_WE = $urandom_range(0, 2) != 0;
            A_BE = NBL'($urandom);
            A_WD = $urandom;
            A_Ad = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            B_CE = $urandom_range(0, 2) != 0;
            B_Ad = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            tick();
        end
        Rst = 1'b0;
        idle();
        for (int i = 0; i < 20; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
